// File: rtl/ppu_vram_ctl.sv
// CPU-side $2006/$2007 VRAM access controller and CHR/VRAM port arbiter for the Dendy PPU.
// Optional internal palette RAM is enabled by defining PPU_VRAM_PALETTE_EN.
module ppu_vram_ctl #(
    parameter int unsigned INC_SMALL = 1,
    parameter int unsigned INC_LARGE = 32
) (
    input  logic        clock25,
    input  logic        reset_n,
    input  logic [2:0]  cpu_a,
    input  logic [7:0]  cpu_d,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_q,
    output logic        cpu_busy,
    input  logic        inc32,
    input  logic        ppu_req,
    input  logic [13:0] ppu_a,
    output logic [7:0]  ppu_q,
    output logic [13:0] mem_a,
    output logic [7:0]  mem_d,
    output logic        mem_we,
    input  logic [7:0]  mem_q
`ifdef PPU_VRAM_PALETTE_EN
    ,
    input  logic [4:0]  pal_a,
    output logic [5:0]  pal_q
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StRcap
    } state_e;

    state_e      state_q, state_d;
    logic [13:0] vaddr_q;
    logic        wlatch_q;
    logic [7:0]  rdbuf_q;
    logic [13:0] op_a_q;
    logic [7:0]  op_d_q;
    logic        op_wr_q;
    logic [7:0]  cpu_q_q;

    logic [13:0] vaddr_inc;
    logic        wr_2006;
    logic        rd_2002;
    logic        acc_2007;
    logic        wr_2007;
    logic        rd_2007;
    logic        pal_hit;
    logic        pal_we;
    logic        start_mem;
    logic        issue;
    logic [7:0]  rd7_data;
    logic [13:0] rd_op_a;

    // A simultaneous write strobe masks the read strobe.
    assign wr_2006  = cpu_wr && (cpu_a == 3'd6);
    assign rd_2002  = cpu_rd && !cpu_wr && (cpu_a == 3'd2);
    assign acc_2007 = (cpu_wr || cpu_rd) && (cpu_a == 3'd7) && (state_q == StIdle);
    assign wr_2007  = acc_2007 && cpu_wr;
    assign rd_2007  = acc_2007 && !cpu_wr;

    assign vaddr_inc = inc32 ? 14'(INC_LARGE) : 14'(INC_SMALL);

`ifdef PPU_VRAM_PALETTE_EN
    logic [5:0] pal_ram [32];

    // $3F10/$3F14/$3F18/$3F1C share storage with $3F00/$3F04/$3F08/$3F0C.
    function automatic logic [4:0] pal_mirror(input logic [4:0] idx);
        return (idx[4] && (idx[1:0] == 2'b00)) ? {1'b0, idx[3:0]} : idx;
    endfunction

    assign pal_hit  = (vaddr_q[13:8] == 6'h3F);
    assign pal_we   = wr_2007 && pal_hit;
    assign rd7_data = pal_hit ? {2'b00, pal_ram[pal_mirror(vaddr_q[4:0])]} : rdbuf_q;
    // Palette reads still refill the buffer from the nametable underneath.
    assign rd_op_a  = pal_hit ? (vaddr_q - 14'h1000) : vaddr_q;
    assign pal_q    = pal_ram[pal_mirror(pal_a)];

    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                pal_ram[i] <= '0;
            end
        end else if (pal_we) begin
            pal_ram[pal_mirror(vaddr_q[4:0])] <= cpu_d[5:0];
        end
    end
`else
    assign pal_hit  = 1'b0;
    assign pal_we   = 1'b0;
    assign rd7_data = rdbuf_q;
    assign rd_op_a  = vaddr_q;
`endif

    assign start_mem = rd_2007 || (wr_2007 && !pal_hit);

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_mem) begin
                    state_d = StPend;
                end
            end
            StPend: begin
                if (!ppu_req) begin
                    issue   = 1'b1;
                    state_d = op_wr_q ? StIdle : StRcap;
                end
            end
            StRcap:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign mem_a    = issue ? op_a_q : ppu_a;
    assign mem_d    = op_d_q;
    assign mem_we   = issue && op_wr_q;
    assign ppu_q    = mem_q;
    assign cpu_busy = (state_q != StIdle);
    assign cpu_q    = cpu_q_q;

    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            vaddr_q  <= '0;
            wlatch_q <= 1'b0;
            rdbuf_q  <= '0;
            op_a_q   <= '0;
            op_d_q   <= '0;
            op_wr_q  <= 1'b0;
            cpu_q_q  <= '0;
        end else begin
            if (wr_2006) begin
                if (!wlatch_q) begin
                    vaddr_q[13:8] <= cpu_d[5:0];
                    wlatch_q      <= 1'b1;
                end else begin
                    vaddr_q[7:0] <= cpu_d;
                    wlatch_q     <= 1'b0;
                end
            end else if (rd_2002) begin
                wlatch_q <= 1'b0;
            end

            if (acc_2007) begin
                vaddr_q <= vaddr_q + vaddr_inc;
            end

            if (wr_2007 && !pal_hit) begin
                op_a_q  <= vaddr_q;
                op_d_q  <= cpu_d;
                op_wr_q <= 1'b1;
            end else if (rd_2007) begin
                op_a_q  <= rd_op_a;
                op_wr_q <= 1'b0;
            end

            if (cpu_rd && !cpu_wr) begin
                cpu_q_q <= (cpu_a == 3'd7) ? rd7_data : 8'h00;
            end

            if (state_q == StRcap) begin
                rdbuf_q <= mem_q;
            end
        end
    end

endmodule

// File: tb/tb_ppu_vram_ctl.sv
// Directed self-checking bench for ppu_vram_ctl in its default build (no palette RAM).
// A synchronous 16K x 8 memory model answers the memory port with one cycle of latency.
module tb_ppu_vram_ctl;

    logic        clock25 = 1'b0;
    logic        reset_n;
    logic [2:0]  cpu_a;
    logic [7:0]  cpu_d;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_q;
    logic        cpu_busy;
    logic        inc32;
    logic        ppu_req;
    logic [13:0] ppu_a;
    logic [7:0]  ppu_q;
    logic [13:0] mem_a;
    logic [7:0]  mem_d;
    logic        mem_we;
    logic [7:0]  mem_q;

    logic [7:0]  vram [16384];

    int n_checks = 0;
    int n_errs   = 0;

    ppu_vram_ctl dut (
        .clock25  (clock25),
        .reset_n  (reset_n),
        .cpu_a    (cpu_a),
        .cpu_d    (cpu_d),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_q    (cpu_q),
        .cpu_busy (cpu_busy),
        .inc32    (inc32),
        .ppu_req  (ppu_req),
        .ppu_a    (ppu_a),
        .ppu_q    (ppu_q),
        .mem_a    (mem_a),
        .mem_d    (mem_d),
        .mem_we   (mem_we),
        .mem_q    (mem_q)
    );

    always #5 clock25 = ~clock25;

    always @(posedge clock25) begin
        if (mem_we) vram[mem_a] <= mem_d;
        mem_q <= vram[mem_a];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clock25);
        #1;
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
        cpu_a  = a;
        cpu_d  = d;
        cpu_wr = 1'b1;
        cyc();
        cpu_wr = 1'b0;
    endtask

    task automatic reg_rd(input logic [2:0] a);
        cpu_a  = a;
        cpu_rd = 1'b1;
        cyc();
        cpu_rd = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
        vram[14'h2400] = 8'h77;
        reset_n = 1'b0;
        cpu_a   = 3'd0;
        cpu_d   = 8'h00;
        cpu_rd  = 1'b0;
        cpu_wr  = 1'b0;
        inc32   = 1'b0;
        ppu_req = 1'b0;
        ppu_a   = 14'h0123;
        cyc();
        cyc();

        check("rst_cpu_q", cpu_q, 8'h00);
        check("rst_busy", cpu_busy, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_a", mem_a, 14'h0123);
        reset_n = 1'b1;
        cyc();

        // Basic write: $2108 <- $5A.
        reg_wr(3'd6, 8'h21);
        reg_wr(3'd6, 8'h08);
        reg_wr(3'd7, 8'h5A);
        check("wr_mem_a", mem_a, 14'h2108);
        check("wr_mem_d", mem_d, 8'h5A);
        check("wr_mem_we", mem_we, 1'b1);
        check("wr_busy", cpu_busy, 1'b1);
        cyc();
        check("wr_busy_done", cpu_busy, 1'b0);
        check("wr_we_done", mem_we, 1'b0);
        check("wr_stored", vram[14'h2108], 8'h5A);
        reg_wr(3'd7, 8'h11);
        check("wr_inc1", mem_a, 14'h2109);
        cyc();

        // Increment of 32 wraps at 14 bits.
        inc32 = 1'b1;
        reg_wr(3'd6, 8'h3F);
        reg_wr(3'd6, 8'hF0);
        reg_wr(3'd7, 8'h33);
        check("inc32_a0", mem_a, 14'h3FF0);
        cyc();
        reg_wr(3'd7, 8'h44);
        check("inc32_wrap", mem_a, 14'h0010);
        cyc();
        inc32 = 1'b0;

        // Buffered reads.
        reg_wr(3'd6, 8'h24);
        reg_wr(3'd6, 8'h00);
        reg_rd(3'd7);
        check("rd1_cpu_q", cpu_q, 8'h00);
        check("rd1_mem_a", mem_a, 14'h2400);
        check("rd1_busy", cpu_busy, 1'b1);
        check("rd1_no_we", mem_we, 1'b0);
        cyc();
        check("rd1_rcap_busy", cpu_busy, 1'b1);
        cyc();
        check("rd1_idle", cpu_busy, 1'b0);
        reg_rd(3'd7);
        check("rd2_cpu_q", cpu_q, 8'h77);
        cyc();
        cyc();

        // Stall behind the PPU for 3 cycles; a second strobe meanwhile is dropped.
        reg_wr(3'd6, 8'h05);
        reg_wr(3'd6, 8'h00);
        ppu_req = 1'b1;
        ppu_a   = 14'h1234;
        reg_wr(3'd7, 8'h99);
        check("stall_c1_we", mem_we, 1'b0);
        check("stall_c1_busy", cpu_busy, 1'b1);
        check("stall_c1_mem_a", mem_a, 14'h1234);
        reg_wr(3'd7, 8'hAA);
        check("stall_c2_we", mem_we, 1'b0);
        check("stall_c2_busy", cpu_busy, 1'b1);
        cyc();
        check("stall_c3_we", mem_we, 1'b0);
        check("stall_c3_busy", cpu_busy, 1'b1);
        cyc();
        ppu_req = 1'b0;
        #1;
        check("stall_c4_we", mem_we, 1'b1);
        check("stall_c4_mem_a", mem_a, 14'h0500);
        check("stall_c4_mem_d", mem_d, 8'h99);
        check("stall_c4_busy", cpu_busy, 1'b1);
        cyc();
        check("stall_c5_busy", cpu_busy, 1'b0);
        check("stall_stored", vram[14'h0500], 8'h99);
        reg_wr(3'd7, 8'h01);
        check("stall_one_inc", mem_a, 14'h0501);
        cyc();

        // $2002 read resets the address latch.
        reg_wr(3'd6, 8'h12);
        reg_rd(3'd2);
        check("rd2002_cpu_q", cpu_q, 8'h00);
        reg_wr(3'd6, 8'h3F);
        reg_wr(3'd6, 8'h10);
        reg_wr(3'd7, 8'h05);
        check("latch_rst_a", mem_a, 14'h3F10);
        cyc();

        // Read and write strobes together: the write is performed.
        cpu_a  = 3'd7;
        cpu_d  = 8'hC3;
        cpu_rd = 1'b1;
        cpu_wr = 1'b1;
        cyc();
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        check("rdwr_we", mem_we, 1'b1);
        check("rdwr_a", mem_a, 14'h3F11);
        check("rdwr_d", mem_d, 8'hC3);
        cyc();

        // Reset during a stalled write discards it.
        ppu_req = 1'b1;
        reg_wr(3'd7, 8'hEE);
        check("rstmid_busy_pre", cpu_busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rstmid_busy", cpu_busy, 1'b0);
        ppu_req = 1'b0;
        #1;
        check("rstmid_we", mem_we, 1'b0);
        cyc();
        cyc();
        check("rstmid_we_later", mem_we, 1'b0);
        check("rstmid_not_stored", vram[14'h3F12], 8'h00);
        reset_n = 1'b1;
        cyc();
        reg_wr(3'd7, 8'h66);
        check("rstmid_vaddr0", mem_a, 14'h0000);
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
